// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl: streams a counted byte program into instruction memory, then releases the CPU from reset
module prog_loader_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              ProgMode,
    output logic [ADDR_W-1:0] Addr_Prog,
    output logic [31:0]       Data_Prog,
    output logic              prog_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic [ADDR_W:0]   words_loaded
);
    typedef enum logic [2:0] {IDLE, COUNT, BYTE, WRITE, RELEASE, RUN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx, n_last;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;
    logic [7:0]        rel_cnt;
    logic              accept, last_word, rel_done;

    assign byte_ready = state == COUNT || state == BYTE;
    assign accept     = byte_valid && byte_ready;
    assign last_word  = idx == n_last;
    assign rel_done   = rel_cnt == 8'(RST_CYCLES - 1);
    assign prog_we    = state == WRITE;
    assign ProgMode   = state == RUN;
    assign cpu_reset  = state != RUN;
    assign busy       = state != IDLE && state != RUN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, RUN: state_nx = start ? COUNT : state;
            COUNT:     state_nx = accept ? BYTE : COUNT;
            BYTE:      state_nx = (accept && byte_cnt == 2'd3) ? WRITE : BYTE;
            WRITE:     state_nx = last_word ? RELEASE : BYTE;
            RELEASE:   state_nx = rel_done ? RUN : RELEASE;
            default:   state_nx = IDLE;
        endcase
    end

    // n_last holds N-1 so a count byte of 0 naturally selects the full 2^ADDR_W space
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx          <= '0;
            n_last       <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            rel_cnt      <= '0;
            Addr_Prog    <= '0;
            Data_Prog    <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE, RUN: if (start) begin
                    words_loaded <= '0;
                    byte_cnt     <= '0;
                end
                COUNT: if (accept) begin
                    n_last   <= (byte_in == 8'd0) ? '1 : ADDR_W'(byte_in - 8'd1);
                    idx      <= '0;
                    byte_cnt <= '0;
                end
                BYTE: if (accept) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        Addr_Prog <= idx;
                        Data_Prog <= {asm_q, byte_in};
                    end else begin
                        asm_q <= {asm_q[15:0], byte_in};
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + (ADDR_W+1)'(1);
                    rel_cnt      <= '0;
                    if (!last_word) idx <= idx + ADDR_W'(1);
                end
                RELEASE: rel_cnt <= rel_cnt + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader_ctrl.sv
// tb_prog_loader_ctrl: directed loads checked against a write scoreboard
module tb_prog_loader_ctrl;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0, reset, start, byte_valid, byte_ready;
    logic [7:0]        byte_in;
    logic              ProgMode, prog_we, cpu_reset, busy;
    logic [ADDR_W-1:0] Addr_Prog;
    logic [31:0]       Data_Prog;
    logic [ADDR_W:0]   words_loaded;

    typedef struct {logic [ADDR_W-1:0] addr; logic [31:0] data;} wr_t;
    wr_t         sb[$];
    logic [31:0] prog[$];
    int          n_checks = 0, n_pass = 0;

    prog_loader_ctrl #(.ADDR_W(ADDR_W), .RST_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .ProgMode(ProgMode),
        .Addr_Prog(Addr_Prog), .Data_Prog(Data_Prog), .prog_we(prog_we),
        .cpu_reset(cpu_reset), .busy(busy), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // every cycle boundary passes through here, so each write strobe is matched once
    task automatic step();
        wr_t e;
        @(negedge clk);
        if (prog_we === 1'b1) begin
            if (sb.size() == 0) check("unexpected_we", {63'd0, prog_we}, 64'd0);
            else begin
                e = sb.pop_front();
                check("wr_addr", {56'd0, Addr_Prog}, {56'd0, e.addr});
                check("wr_data", {32'd0, Data_Prog}, {32'd0, e.data});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc = 0;
        int n = 0;
        while (!acc && n < 64) begin
            byte_in    = b;
            byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            acc        = byte_valid && byte_ready;
            step();
            n++;
        end
        byte_valid = 1'b0;
        if (!acc) check("byte_timeout", {63'd0, acc}, 64'd1);
    endtask

    task automatic begin_load();
        start = 1'b1;
        step();
        start = 1'b0;
        check("count_state", {60'd0, busy, byte_ready, ProgMode, cpu_reset}, 64'b1101);
        check("count_words", {55'd0, words_loaded}, 64'd0);
    endtask

    task automatic send_words(input int nw, input bit gaps, input int start_at);
        logic [31:0] wd;
        for (int w = 0; w < nw; w++) begin
            wd = prog[w];
            sb.push_back('{addr: ADDR_W'(w), data: wd});
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b == start_at) start = 1'b1;
                send_byte(wd[31 - 8 * b -: 8], gaps);
                start = 1'b0;
            end
        end
    endtask

    task automatic finish_load(input int nw);
        int k = 0;
        while (ProgMode !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("release_cycles", 64'(k - 1), 64'd4);
        check("run_state", {61'd0, ProgMode, cpu_reset, busy}, 64'b100);
        check("words_loaded", {55'd0, words_loaded}, 64'(nw));
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        step();
        check("rst_ctrl", {59'd0, ProgMode, cpu_reset, prog_we, byte_ready, busy}, 64'b01000);
        check("rst_data", {Addr_Prog, Data_Prog}, 64'd0);
        reset = 1'b1;
        repeat (2) step();
        check("idle_hold", {62'd0, ProgMode, cpu_reset}, 64'b01);

        // basic 5-word program
        prog = '{32'h10200005, 32'h10400003, 32'h00000004, 32'h00811005, 32'h00211004};
        begin_load();
        send_byte(8'h05, 1'b0);
        send_words(5, 1'b0, -1);
        finish_load(5);

        // reload from RUN with random valid gaps and a start pulse mid-BYTE
        begin_load();
        send_byte(8'h05, 1'b1);
        send_words(5, 1'b1, 6);
        finish_load(5);
        check("last_addr_hold", {56'd0, Addr_Prog}, 64'd4);
        check("last_data_hold", {32'd0, Data_Prog}, 64'h00211004);

        // count byte 0 selects the full 256-word space
        prog.delete();
        for (int i = 0; i < 256; i++) prog.push_back(32'(i));
        begin_load();
        send_byte(8'h00, 1'b0);
        send_words(256, 1'b0, -1);
        finish_load(256);
        check("full_last_addr", {56'd0, Addr_Prog}, 64'hFF);
        check("full_last_data", {32'd0, Data_Prog}, 64'hFF);

        // reset after two bytes of word 3
        prog = '{32'h10200005, 32'h10400003, 32'h00000004, 32'h00811005, 32'h00211004};
        begin_load();
        send_byte(8'h05, 1'b0);
        send_words(3, 1'b0, -1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h81, 1'b0);
        reset = 1'b0;
        #1;
        check("async_rst_ctrl", {59'd0, ProgMode, cpu_reset, prog_we, byte_ready, busy}, 64'b01000);
        check("async_rst_data", {Addr_Prog, Data_Prog}, 64'd0);
        check("async_rst_words", {55'd0, words_loaded}, 64'd0);
        step();
        reset = 1'b1;
        byte_valid = 1'b1;
        repeat (6) step();
        byte_valid = 1'b0;
        check("post_rst_idle", {62'd0, busy, cpu_reset}, 64'b01);

        prog = '{32'hCAFEF00D};
        begin_load();
        send_byte(8'h01, 1'b0);
        send_words(1, 1'b0, -1);
        finish_load(1);
        check("one_word_addr", {56'd0, Addr_Prog}, 64'd0);
        check("one_word_data", {32'd0, Data_Prog}, 64'hCAFEF00D);
        repeat (3) step();
        check("run_stays", {62'd0, ProgMode, cpu_reset}, 64'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
